// File: rtl/uc_drv_pkg.sv
// Shared types and default widths for the up/down counter command driver.
//   uc_op_e    : command opcodes carried on cmd_op
//   uc_state_e : driver sequencer states
package uc_drv_pkg;

  localparam int unsigned UC_WIDTH_DEF = 4;
  localparam int unsigned UC_LEN_W_DEF = 4;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_LOAD  = 2'd1,
    OP_COUNT = 2'd2,
    OP_HOLD  = 2'd3
  } uc_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } uc_state_e;

endpackage

// File: rtl/uc_ref_model.sv
// Expected-count register mirroring the universal up/down counter.
// Samples the same registered controls the counter sees, so after every
// clock edge q_o equals the counter's q.
//   clk, rst        : clock, asynchronous active-high reset
//   clr_i           : clear to zero (highest priority)
//   load_i, data_i  : parallel load
//   en_i, up_i      : count enable, direction (1 = up), wraps modulo 2^WIDTH
//   q_o             : expected counter value
module uc_ref_model
  import uc_drv_pkg::*;
#(
  parameter int unsigned WIDTH = UC_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] q_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] exp_q, exp_d;

  always_comb begin
    exp_d = exp_q;
    if (clr_i) begin
      exp_d = '0;
    end else if (load_i) begin
      exp_d = data_i;
    end else if (en_i) begin
      exp_d = up_i ? (exp_q + ONE) : (exp_q - ONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q <= '0;
    end else begin
      exp_q <= exp_d;
    end
  end

  assign q_o = exp_q;

endmodule

// File: rtl/uc_cmd_driver.sv
// Command-driven control sequencer for the universal up/down counter.
// Accepts CLEAR/LOAD/COUNT/HOLD commands over valid/ready and drives the
// counter's registered control strobes for the commanded number of cycles,
// while keeping a cycle-exact expected-count model.
//   clk, clr            : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready : command handshake
//   cmd_op, cmd_dir     : opcode, COUNT direction (1 = up)
//   cmd_data            : LOAD value
//   cmd_len             : COUNT/HOLD length, 0 means 2^LEN_W
//   cnt_*               : registered counter controls
//   q_in                : counter output (checker only)
//   exp_q               : expected counter value
//   busy, done          : executing, last active cycle pulse
//   err                 : sticky q_in/exp_q mismatch
// Optional checker: define UC_DRV_CHECK_EN to build the q_in comparison;
// otherwise err is tied low and q_in is ignored.
module uc_cmd_driver
  import uc_drv_pkg::*;
#(
  parameter int unsigned WIDTH = UC_WIDTH_DEF,
  parameter int unsigned LEN_W = UC_LEN_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_dir,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cnt_clr,
  output logic             cnt_load,
  output logic             cnt_en,
  output logic             cnt_up_down,
  output logic [WIDTH-1:0] cnt_data,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] exp_q,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [LEN_W:0] LEN_ONE = (LEN_W + 1)'(1);
  localparam logic [LEN_W:0] LEN_MAX = {1'b1, {LEN_W{1'b0}}};

  uc_state_e        state_q, state_d;
  logic [LEN_W:0]   rem_q, rem_d;
  logic             cnt_clr_q, cnt_clr_d;
  logic             cnt_load_q, cnt_load_d;
  logic             cnt_en_q, cnt_en_d;
  logic             cnt_up_down_q, cnt_up_down_d;
  logic [WIDTH-1:0] cnt_data_q, cnt_data_d;

  logic             accept;
  logic             last;
  logic [LEN_W:0]   len_n;

  assign cmd_ready = (state_q == ST_IDLE) && !clr;
  assign accept    = cmd_valid && cmd_ready;
  assign last      = (state_q == ST_RUN) && (rem_q == LEN_ONE);
  assign len_n     = (cmd_len == '0) ? LEN_MAX : {1'b0, cmd_len};

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    cnt_clr_d     = cnt_clr_q;
    cnt_load_d    = cnt_load_q;
    cnt_en_d      = cnt_en_q;
    cnt_up_down_d = cnt_up_down_q;
    cnt_data_d    = cnt_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RUN;
          case (uc_op_e'(cmd_op))
            OP_CLEAR: begin
              cnt_clr_d = 1'b1;
              rem_d     = LEN_ONE;
            end
            OP_LOAD: begin
              cnt_load_d = 1'b1;
              cnt_data_d = cmd_data;
              rem_d      = LEN_ONE;
            end
            OP_COUNT: begin
              cnt_en_d      = 1'b1;
              cnt_up_down_d = cmd_dir;
              rem_d         = len_n;
            end
            default: begin
              rem_d = len_n;
            end
          endcase
        end
      end
      default: begin
        if (last) begin
          state_d    = ST_IDLE;
          rem_d      = '0;
          cnt_clr_d  = 1'b0;
          cnt_load_d = 1'b0;
          cnt_en_d   = 1'b0;
        end else begin
          rem_d = rem_q - LEN_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q       <= ST_IDLE;
      rem_q         <= '0;
      cnt_clr_q     <= 1'b0;
      cnt_load_q    <= 1'b0;
      cnt_en_q      <= 1'b0;
      cnt_up_down_q <= 1'b0;
      cnt_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      cnt_clr_q     <= cnt_clr_d;
      cnt_load_q    <= cnt_load_d;
      cnt_en_q      <= cnt_en_d;
      cnt_up_down_q <= cnt_up_down_d;
      cnt_data_q    <= cnt_data_d;
    end
  end

  uc_ref_model #(
    .WIDTH(WIDTH)
  ) u_ref_model (
    .clk    (clk),
    .rst    (clr),
    .clr_i  (cnt_clr_q),
    .load_i (cnt_load_q),
    .en_i   (cnt_en_q),
    .up_i   (cnt_up_down_q),
    .data_i (cnt_data_q),
    .q_o    (exp_q)
  );

`ifdef UC_DRV_CHECK_EN
  logic err_q, err_d;

  // The counter clears asynchronously, so q_in leads exp_q by one cycle
  // while cnt_clr is high; that cycle is excluded from the comparison.
  always_comb begin
    err_d = err_q;
    if (!cnt_clr_q && (q_in != exp_q)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_q_in;
  assign unused_q_in = ^q_in;
  assign err         = 1'b0;
`endif

  assign cnt_clr     = cnt_clr_q;
  assign cnt_load    = cnt_load_q;
  assign cnt_en      = cnt_en_q;
  assign cnt_up_down = cnt_up_down_q;
  assign cnt_data    = cnt_data_q;
  assign busy        = (state_q == ST_RUN);
  assign done        = last;

endmodule

// File: tb/tb_uc_cmd_driver.sv
// Self-checking bench for uc_cmd_driver: a table of commands with
// hand-computed results, plus directed sequences for handshake stalls,
// mid-run reset and the optional checker.
module tb_uc_cmd_driver;

`ifdef UC_DRV_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic       clk;
  logic       clr;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_dir;
  logic [3:0] cmd_data;
  logic [3:0] cmd_len;
  logic       cnt_clr, cnt_load, cnt_en, cnt_up_down;
  logic [3:0] cnt_data;
  logic [3:0] q_in;
  logic [3:0] exp_q;
  logic       busy, done, err;

  // Behavioural universal counter with asynchronous clear.
  logic [3:0] cq;
  logic       force_en;
  logic [3:0] force_val;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  uc_cmd_driver #(
    .WIDTH(4),
    .LEN_W(4)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_dir     (cmd_dir),
    .cmd_data    (cmd_data),
    .cmd_len     (cmd_len),
    .cnt_clr     (cnt_clr),
    .cnt_load    (cnt_load),
    .cnt_en      (cnt_en),
    .cnt_up_down (cnt_up_down),
    .cnt_data    (cnt_data),
    .q_in        (q_in),
    .exp_q       (exp_q),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge clr or posedge cnt_clr) begin
    if (clr || cnt_clr) cq <= 4'h0;
    else if (cnt_load) cq <= cnt_data;
    else if (cnt_en)   cq <= cnt_up_down ? cq + 4'h1 : cq - 4'h1;
  end

  assign q_in = force_en ? force_val : cq;

  typedef struct {
    logic [1:0]  op;
    logic        dir;
    logic [3:0]  data;
    logic [3:0]  len;
    int unsigned n;
    logic [3:0]  exp_final;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic run_cmd(input int idx, input vec_t v);
    int unsigned busy_c, clr_c, load_c, en_c, done_c, done_at, multi_c, qbad_c, ctl_bad;
    int guard;
    busy_c = 0; clr_c = 0; load_c = 0; en_c = 0; done_c = 0; done_at = 0;
    multi_c = 0; qbad_c = 0; ctl_bad = 0;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("v%0d_ready", idx), 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_dir   = v.dir;
    cmd_data  = v.data;
    cmd_len   = v.len;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 40) begin
      busy_c++;
      clr_c  += 32'(cnt_clr);
      load_c += 32'(cnt_load);
      en_c   += 32'(cnt_en);
      if (done) begin
        done_c++;
        done_at = busy_c;
      end
      if ((32'(cnt_clr) + 32'(cnt_load) + 32'(cnt_en)) > 1) multi_c++;
      if (!cnt_clr && (q_in != exp_q)) qbad_c++;
      if (cnt_en && (cnt_up_down != v.dir)) ctl_bad++;
      if (cnt_load && (cnt_data != v.data)) ctl_bad++;
      if (cmd_ready) ctl_bad++;
      @(negedge clk);
      guard++;
    end
    check($sformatf("v%0d_busy_cycles", idx), busy_c, v.n);
    check($sformatf("v%0d_clr_cycles", idx), clr_c, (v.op == 2'd0) ? 32'd1 : 32'd0);
    check($sformatf("v%0d_load_cycles", idx), load_c, (v.op == 2'd1) ? 32'd1 : 32'd0);
    check($sformatf("v%0d_en_cycles", idx), en_c, (v.op == 2'd2) ? v.n : 32'd0);
    check($sformatf("v%0d_done_count", idx), done_c, 32'd1);
    check($sformatf("v%0d_done_last", idx), done_at, v.n);
    check($sformatf("v%0d_onehot", idx), multi_c, 32'd0);
    check($sformatf("v%0d_q_track", idx), qbad_c, 32'd0);
    check($sformatf("v%0d_ctl", idx), ctl_bad, 32'd0);
    check($sformatf("v%0d_exp_q", idx), 32'(exp_q), 32'(v.exp_final));
    check($sformatf("v%0d_idle_ready", idx), 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] held;
    int unsigned done_seen;
    vec_t tmp;

    vecs[0] = '{2'd0, 1'b0, 4'h0, 4'd0, 1,  4'h0};  // CLEAR
    vecs[1] = '{2'd1, 1'b0, 4'hA, 4'd0, 1,  4'hA};  // LOAD 1010
    vecs[2] = '{2'd2, 1'b1, 4'h0, 4'd4, 4,  4'hE};  // COUNT up 4
    vecs[3] = '{2'd2, 1'b0, 4'h0, 4'd4, 4,  4'hA};  // COUNT down 4
    vecs[4] = '{2'd1, 1'b0, 4'hE, 4'd0, 1,  4'hE};  // LOAD 1110
    vecs[5] = '{2'd2, 1'b1, 4'h0, 4'd3, 3,  4'h1};  // up wrap -> 0001
    vecs[6] = '{2'd1, 1'b0, 4'h1, 4'd0, 1,  4'h1};  // LOAD 0001
    vecs[7] = '{2'd2, 1'b0, 4'h0, 4'd2, 2,  4'hF};  // down wrap -> 1111
    vecs[8] = '{2'd2, 1'b1, 4'h0, 4'd0, 16, 4'hF};  // len 0 = 16 cycles
    vecs[9] = '{2'd3, 1'b0, 4'h0, 4'd5, 5,  4'hF};  // HOLD 5

    clr = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_dir = 1'b0;
    cmd_data = 4'h0; cmd_len = 4'd0; force_en = 1'b0; force_val = 4'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready_low", 32'(cmd_ready), 32'd0);
    clr = 1'b0;
    @(negedge clk);
    check("rst_strobes", {cnt_clr, cnt_load, cnt_en, cnt_up_down}, 32'd0);
    check("rst_cnt_data", 32'(cnt_data), 32'd0);
    check("rst_exp_q", 32'(exp_q), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy_done", {busy, done}, 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 10; i++) run_cmd(i, vecs[i]);

    // HOLD 2 with cmd_valid held high; a LOAD 0101 waits behind it.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_len = 4'd2; cmd_data = 4'h5; cmd_dir = 1'b1;
    held = exp_q;
    @(posedge clk);
    #1 cmd_op = 2'd1;
    @(negedge clk);
    check("hold_c1_ready", 32'(cmd_ready), 32'd0);
    check("hold_c1_strobes", {cnt_clr, cnt_load, cnt_en, busy, done}, 32'b00010);
    check("hold_c1_exp", 32'(exp_q), 32'(held));
    @(negedge clk);
    check("hold_c2_ready", 32'(cmd_ready), 32'd0);
    check("hold_c2_strobes", {cnt_clr, cnt_load, cnt_en, busy, done}, 32'b00011);
    check("hold_c2_exp", 32'(exp_q), 32'(held));
    @(negedge clk);
    check("hold_after_ready", {cmd_ready, busy}, 32'b10);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("queued_load", {cnt_load, cnt_data}, {27'd0, 1'b1, 4'h5});
    check("queued_load_done", 32'(done), 32'd1);
    @(negedge clk);
    check("queued_load_exp", {busy, exp_q}, {27'd0, 1'b0, 4'h5});

    // Reset in the 2nd cycle of COUNT up len 8.
    tmp = '{2'd2, 1'b1, 4'h0, 4'd8, 8, 4'h0};
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = tmp.op; cmd_dir = tmp.dir; cmd_len = tmp.len;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("midrst_c1_en", {cnt_en, busy}, 32'b11);
    @(posedge clk);
    #1 clr = 1'b1;
    #1;
    check("midrst_outputs", {cnt_clr, cnt_load, cnt_en, cnt_up_down, busy, done, cmd_ready},
          32'd0);
    check("midrst_exp_q", 32'(exp_q), 32'd0);
    done_seen = 0;
    repeat (2) begin
      @(negedge clk);
      done_seen += 32'(done);
    end
    clr = 1'b0;
    repeat (3) begin
      @(negedge clk);
      done_seen += 32'(done);
    end
    check("midrst_no_done", done_seen, 32'd0);
    check("midrst_idle", {busy, cmd_ready, cnt_en}, 32'b010);
    check("midrst_exp_hold", 32'(exp_q), 32'd0);

    // Checker: CLEAR cycle is masked, then a forced mismatch.
    tmp = '{2'd1, 1'b0, 4'h2, 4'd0, 1, 4'h2};
    run_cmd(20, tmp);
    tmp = '{2'd0, 1'b0, 4'h0, 4'd0, 1, 4'h0};
    run_cmd(21, tmp);
    check("mask_clear_err", 32'(err), 32'd0);
    tmp = '{2'd1, 1'b0, 4'h2, 4'd0, 1, 4'h2};
    run_cmd(22, tmp);
    check("pre_force_err", 32'(err), 32'd0);
    force_val = 4'h3;
    force_en  = 1'b1;
    @(negedge clk);
    force_en  = 1'b0;
    check("force_err_set", 32'(err), 32'(CHK));
    repeat (3) @(negedge clk);
    check("force_err_sticky", 32'(err), 32'(CHK));
    check("force_exp_q", 32'(exp_q), 32'h2);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("err_cleared_by_reset", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uc_cmd_driver.md
# uc_cmd_driver

Command-driven control sequencer for the universal up/down counter. It accepts opcodes over a valid/ready handshake and drives the counter's clear, load, enable, direction and data inputs for the commanded number of cycles. It keeps a cycle-exact expected-count model, and it sits between a test or control master and the counter instance. An optional checker compares the counter's `q` against the model.

## Interface
- `WIDTH`, 4: counter data width.
- `LEN_W`, 4: run-length field width.
- `clk`  in  1: rising-edge clock.
- `clr`  in  1: asynchronous active-high reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: driver can accept a command.
- `cmd_op`  in  2: opcode; 0 CLEAR, 1 LOAD, 2 COUNT, 3 HOLD.
- `cmd_dir`  in  1: COUNT direction; 1 = up, 0 = down.
- `cmd_data`  in  WIDTH: LOAD value.
- `cmd_len`  in  LEN_W: COUNT/HOLD cycles; 0 encodes 2^LEN_W.
- `cnt_clr`, `cnt_load`, `cnt_en`, `cnt_up_down`  out  1 each: counter controls, all registered.
- `cnt_data`  out  WIDTH: counter load data, registered.
- `q_in`  in  WIDTH: counter output, for the checker.
- `exp_q`  out  WIDTH: expected counter value.
- `busy`  out  1: a command is executing.
- `done`  out  1: one-cycle pulse in the last active cycle of a command.
- `err`  out  1: sticky mismatch flag.

## Operation
- FSM states are IDLE and RUN.
- `cmd_ready` = (state == IDLE). No command is accepted while `clr` is high.
- A command is accepted on a rising edge with `cmd_valid && cmd_ready`. The FSM enters RUN, and the control outputs take effect from the next cycle.
- CLEAR: `cnt_clr`=1 for 1 cycle. `exp_q`←0 at the end of that cycle.
- LOAD: `cnt_load`=1 and `cnt_data`=`cmd_data` for 1 cycle. `exp_q`←`cmd_data`.
- COUNT: `cnt_en`=1 and `cnt_up_down`=`cmd_dir` for N cycles. `exp_q` steps ±1 per cycle modulo 2^WIDTH, wrapping 1111→0000 up and 0000→1111 down.
- HOLD: all strobes 0 for N cycles. `exp_q` is unchanged.
- A down-counter loaded with N (or 2^LEN_W when `cmd_len`=0) tracks the remaining cycles.
- In the final RUN cycle: `done`=1, then the FSM returns to IDLE and all strobes drop to 0.
- At most one of `cnt_clr`, `cnt_load`, `cnt_en` is ever high.
- `cnt_up_down` and `cnt_data` hold their last values when idle.
- `busy` = (state == RUN).
- Reset (asynchronous, any time, including mid-RUN) forces:
  - state IDLE;
  - all outputs and `exp_q` to 0;
  - the run counter to 0;
  - `err` to 0.
- The command in flight is discarded.

## Timing
- Command accepted at edge k → control active in cycles k+1 … k+N.
- `done` is asserted in cycle k+N.
- `cmd_ready` is high again in cycle k+N+1.
- Throughput is one command per N+1 cycles; CLEAR and LOAD take 2 cycles.
- `exp_q` updates on the same edge on which the counter samples its controls, so after every edge `exp_q` equals the counter's `q`.
- Exception: the counter clears asynchronously, so during the `cnt_clr` cycle `q_in`=0 while `exp_q` still holds its old value.

## Configuration
- `UC_DRV_CHECK_EN` defined:
  - Each cycle with `clr`=0 and `cnt_clr`=0, `q_in` != `exp_q` sets `err`.
  - `err` stays set until reset.
  - The comparison uses the registered values of the same cycle.
- `UC_DRV_CHECK_EN` undefined:
  - The checker is not built.
  - `err` is tied to 0 and `q_in` is ignored.

## Structure
- Package `uc_drv_pkg`:
  - opcode enum (OP_CLEAR, OP_LOAD, OP_COUNT, OP_HOLD);
  - FSM state enum;
  - default widths.
- Sub-module `uc_ref_model`: the expected-count register, with clear, load and up/down-wrap behaviour matching the counter. It is instantiated once.

## Test plan
- Reset held for 2 cycles, then released → all strobes 0, `exp_q`=0000, `err`=0; `cmd_ready`=1 on the first cycle after release.
- CLEAR, then LOAD `cmd_data`=1010 → `cnt_clr` pulses for 1 cycle, then `cnt_load`=1 with `cnt_data`=1010; `exp_q`=1010; `done` pulses once per command.
- COUNT up, len 4, from 1010 → `cnt_en` high for exactly 4 cycles, `exp_q`=1110, `done` in the 4th cycle; then COUNT down, len 4 → `exp_q`=1010.
- Wrap: LOAD 1110, COUNT up len 3 → `exp_q` runs 1111, 0000, 0001. LOAD 0001, COUNT down len 2 → `exp_q`=1111. `cmd_len`=0 yields 16 enable cycles.
- HOLD, len 2, with `cmd_valid` held high throughout → no strobes, `exp_q` stable, `cmd_ready`=0 for 2 cycles, and the next command is accepted only after `done`.
- Reset asserted in cycle 2 of a COUNT len 8 → outputs 0 immediately, no `done`, FSM in IDLE.
- With `UC_DRV_CHECK_EN` defined: force `q_in`=0011 while `exp_q`=0010 → `err`=1 and it stays set.
- Checker masking: no `err` is raised during a CLEAR cycle.
